decode_mul_sched: RTL

DECODE_MUL_SCHED -- requirements
Module: decode_mul_sched

---
 rtl/decode_mul_sched_if.sv | 34 +++
 rtl/decode_mul_sched.sv | 107 ++++++++++
 2 files changed

// File: rtl/decode_mul_sched_if.sv
// Bundle of the requester, multiplier and response signals around the shared-multiplier scheduler.
// The scheduler connects through the master modport; the surrounding logic uses the slave modport.
interface decode_mul_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 40,
  parameter int B_WIDTH = 33,
  parameter int P_WIDTH = 70
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       mul_ce;
  logic [A_WIDTH-1:0]         mul_din0;
  logic [B_WIDTH-1:0]         mul_din1;
  logic [P_WIDTH-1:0]         mul_dout;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [P_WIDTH-1:0]         rsp_data;
  logic                       busy;

  modport master (
    input  req_valid, req_a, req_b, mul_dout, rsp_ready,
    output req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    output req_valid, req_a, req_b, mul_dout, rsp_ready,
    input  req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/decode_mul_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NUM_REQ requesters.
// A tag pipeline tracks the multiplier stages; everything stalls together when the output is held.
module decode_mul_sched #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 40,
  parameter int B_WIDTH = 33,
  parameter int P_WIDTH = 70,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  decode_mul_sched_if.master bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [MUL_LAT-1:0] tag_valid_reg;
  logic [MUL_LAT-1:0] tag_valid_next;
  logic [ID_W-1:0]    tag_id_reg  [MUL_LAT];
  logic [ID_W-1:0]    tag_id_next [MUL_LAT];
  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    ptr_next;

  logic               advance;
  logic               accept;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [A_WIDTH-1:0] a_slice [NUM_REQ];
  logic [B_WIDTH-1:0] b_slice [NUM_REQ];

  assign advance = !(tag_valid_reg[MUL_LAT-1] && !bus.rsp_ready);
  assign accept  = advance && win_found && reset;

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin : arbiter
    int              idx;
    logic [ID_W-1:0] idx_w;
    idx       = 0;
    idx_w     = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = ID_W'(idx);
      if (!win_found && bus.req_valid[idx_w]) begin
        win_found = 1'b1;
        win_id    = idx_w;
      end
    end
  end

  assign ptr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_slice[gi]       = bus.req_a[gi*A_WIDTH +: A_WIDTH];
      assign b_slice[gi]       = bus.req_b[gi*B_WIDTH +: B_WIDTH];
      assign bus.req_ready[gi] = accept && (win_id == ID_W'(gi));
    end

    for (gi = 0; gi < MUL_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_next[gi] = accept;
        assign tag_id_next[gi]    = accept ? win_id : '0;
      end else begin : g_body
        assign tag_valid_next[gi] = tag_valid_reg[gi-1];
        assign tag_id_next[gi]    = tag_id_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    bus.mul_din0 = '0;
    bus.mul_din1 = '0;
    if (win_found) begin
      bus.mul_din0 = a_slice[win_id];
      bus.mul_din1 = b_slice[win_id];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid_reg <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_id_reg[i] <= '0;
      end
      ptr_reg <= '0;
    end else if (advance) begin
      tag_valid_reg <= tag_valid_next;
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_id_reg[i] <= tag_id_next[i];
      end
      if (accept) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  assign bus.mul_ce    = advance;
  assign bus.rsp_valid = tag_valid_reg[MUL_LAT-1];
  assign bus.rsp_id    = tag_id_reg[MUL_LAT-1];
  assign bus.rsp_data  = bus.mul_dout;
  assign bus.busy      = |tag_valid_reg;
endmodule
